// File: rtl/dmem_wb_pkg.sv
// Shared types and defaults for the data-memory write buffer.
// Optional store coalescing is enabled with WB_COALESCE_EN.
package dmem_wb_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_ADDR_W = 6;
  localparam int WB_WR_LAT = 4;
  localparam int WORD_OFS  = 2;

  typedef enum logic {
    WB_IDLE,
    WB_WRITE
  } wb_state_t;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] idx;
    logic [31:0]          data;
  } wb_entry_t;

endpackage

// File: rtl/dmem_wb_fifo.sv
// Write-buffer entry storage, pointers and occupancy count.
// Entries are also presented oldest-first for the load forwarding path.
module dmem_wb_fifo
  import dmem_wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_ADDR_W,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] pushIdx,
  input  logic [31:0]       pushData,
  input  logic              pop,
  input  logic              merge,
  output logic [CW-1:0]     count,
  output logic [ADDR_W-1:0] headIdx,
  output logic [31:0]       headData,
  output logic [ADDR_W-1:0] tailIdx,
  output logic              ageValid [DEPTH],
  output logic [ADDR_W-1:0] ageIdx   [DEPTH],
  output logic [31:0]       ageData  [DEPTH]
);

  logic [ADDR_W-1:0] idxQ  [DEPTH];
  logic [31:0]       dataQ [DEPTH];
  logic [PW-1:0]     headPtr;
  logic [PW-1:0]     tailPtr;
  logic [PW-1:0]     lastPtr;

  assign lastPtr  = tailPtr - PW'(1);
  assign headIdx  = idxQ[headPtr];
  assign headData = dataQ[headPtr];
  assign tailIdx  = idxQ[lastPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + PW'(1);
      if (pop)  headPtr <= headPtr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      idxQ[tailPtr]  <= pushIdx;
      dataQ[tailPtr] <= pushData;
    end
    if (merge) dataQ[lastPtr] <= pushData;
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ageValid[k] = CW'(k) < count;
      ageIdx[k]   = idxQ[headPtr + PW'(k)];
      ageData[k]  = dataQ[headPtr + PW'(k)];
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// M-stage data memory with a posted write buffer and slow backing array.
// Define WB_COALESCE_EN to merge stores that hit the youngest entry.
module dmem_write_buffer
  import dmem_wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int WR_LAT = WB_WR_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemBusyM
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = $clog2(WR_LAT + 1);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  wb_state_t         state;
  logic [LW-1:0]     lat;
  logic              push;
  logic              pop;
  logic              merge;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] headIdx;
  logic [31:0]       headData;
  logic [ADDR_W-1:0] tailIdx;
  logic              ageValid [DEPTH];
  logic [ADDR_W-1:0] ageIdx   [DEPTH];
  logic [31:0]       ageData  [DEPTH];
  logic              full;
  logic              unusedAdr;

  assign idx       = DataAdrM[ADDR_W+WORD_OFS-1:WORD_OFS];
  assign unusedAdr = ^{DataAdrM[31:ADDR_W+WORD_OFS], DataAdrM[WORD_OFS-1:0]};
  assign full      = count == CW'(DEPTH);

`ifdef WB_COALESCE_EN
  // The head under commit is already being copied out, so it cannot absorb data.
  assign merge = MemWriteM && count != '0 && tailIdx == idx
              && !(state == WB_WRITE && count == CW'(1));
`else
  logic unusedTail;
  assign unusedTail = ^tailIdx;
  assign merge      = 1'b0;
`endif

  assign push     = MemWriteM && !merge && !full;
  assign MemBusyM = MemWriteM && !merge && full;
  assign pop      = state == WB_WRITE && lat == '0;

  dmem_wb_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (push),
    .pushIdx (idx),
    .pushData(WriteDataM),
    .pop     (pop),
    .merge   (merge),
    .count   (count),
    .headIdx (headIdx),
    .headData(headData),
    .tailIdx (tailIdx),
    .ageValid(ageValid),
    .ageIdx  (ageIdx),
    .ageData (ageData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WB_IDLE;
      lat   <= '0;
    end else begin
      unique case (state)
        WB_IDLE: begin
          if (count != '0) begin
            state <= WB_WRITE;
            lat   <= LW'(WR_LAT - 1);
          end
        end
        WB_WRITE: begin
          if (lat == '0) state <= WB_IDLE;
          else           lat   <= lat - LW'(1);
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop) mem[headIdx] <= headData;
  end

  // Later (younger) matches override earlier ones.
  always_comb begin
    ReadDataM = mem[idx];
    for (int k = 0; k < DEPTH; k++) begin
      if (ageValid[k] && ageIdx[k] == idx) ReadDataM = ageData[k];
    end
    if (!reset) ReadDataM = '0;
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed checks for dmem_write_buffer (default parameters).
// Expectations follow WB_COALESCE_EN when it is defined.
module tb_dmem_write_buffer;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        memWrite = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_write_buffer dut (
    .clk       (clk),
    .reset     (resetN),
    .MemWriteM (memWrite),
    .DataAdrM  (adr),
    .WriteDataM(wdata),
    .ReadDataM (rdata),
    .MemBusyM  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memWrite = 1'b1;
    adr      = a;
    wdata    = d;
    tick();
    memWrite = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
    adr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic waitEmpty(input string tag);
    int n = 0;
    while (dut.u_fifo.count != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(dut.u_fifo.count), 32'd0);
  endtask

  function automatic logic [31:0] pre(input int w);
    return 32'h1000_0000 + 32'(w);
  endfunction

  initial begin
    int n;
    int firstBusy;
    int expBusy;

    #1;
    for (int i = 0; i < 64; i++) dut.mem[i] = pre(i);

    // reset state
    memWrite = 1'b1;
    adr = 32'h10;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    memWrite = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    #1;
    chk("rst count", 32'(dut.u_fifo.count), 32'd0);
    load("rst array", 32'h10, pre(4));

    // 1: forwarding and commit latency
    memWrite = 1'b1;
    adr = 32'h10;
    wdata = 32'hDEADBEEF;
    #1;
    chk("t1 same-cycle", rdata, pre(4));
    tick();
    memWrite = 1'b0;
    load("t1 fwd", 32'h10, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) tick();
    chk("t1 pending", 32'(dut.u_fifo.count), 32'd1);
    tick();
    chk("t1 empty", 32'(dut.u_fifo.count), 32'd0);
    load("t1 array", 32'h10, 32'hDEADBEEF);

    // 2: youngest match wins
    store(32'h20, 32'd1);
    store(32'h20, 32'd2);
    load("t2 fwd", 32'h20, 32'd2);
    waitEmpty("t2 empty");
    load("t2 array", 32'h20, 32'd2);

    // 3: full buffer back-pressure
    for (int i = 0; i < 5; i++) begin
      memWrite = 1'b1;
      adr = 32'h40 + 32'(4 * i);
      wdata = 32'h11 * 32'(i + 1);
      #1;
      chk($sformatf("t3 busy%0d", i), 32'(busy), (i == 4) ? 32'd1 : 32'd0);
      if (i == 4) begin
        n = 0;
        while (busy && n < 20) begin
          tick();
          n++;
        end
        chk("t3 held", 32'(n), 32'd2);
      end
      tick();
    end
    memWrite = 1'b0;
    load("t3 fwd4", 32'h50, 32'h55);
    waitEmpty("t3 empty");
    for (int i = 0; i < 5; i++)
      load($sformatf("t3 word%0d", i), 32'h40 + 32'(4 * i), 32'h11 * 32'(i + 1));

    // 4: address alias and ignored byte bits
    store(32'h104, 32'hA5A5A5A5);
    load("t4 fwd", 32'h004, 32'hA5A5A5A5);
    waitEmpty("t4 empty");
    load("t4 array", 32'h004, 32'hA5A5A5A5);
    load("t4 bytes", 32'h007, 32'hA5A5A5A5);

    // 5: reset discards pending stores
    store(32'h60, 32'd1);
    store(32'h64, 32'd2);
    store(32'h68, 32'd3);
    tick();
    chk("t5 pending", 32'(dut.u_fifo.count), 32'd3);
    resetN = 1'b0;
    memWrite = 1'b1;
    adr = 32'h60;
    #1;
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 rdata", rdata, 32'd0);
    tick();
    memWrite = 1'b0;
    resetN = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("t5 count", 32'(dut.u_fifo.count), 32'd0);
    load("t5 w0", 32'h60, pre(24));
    load("t5 w1", 32'h64, pre(25));
    load("t5 w2", 32'h68, pre(26));

    // 6: repeated stores to one word
    firstBusy = -1;
    for (int i = 0; i < 6; i++) begin
      memWrite = 1'b1;
      adr = 32'h30;
      wdata = 32'(i + 1);
      #1;
      n = 0;
      while (busy && n < 20) begin
        tick();
        n++;
      end
      if (n > 0 && firstBusy < 0) firstBusy = i;
      tick();
    end
    memWrite = 1'b0;
`ifdef WB_COALESCE_EN
    expBusy = -1;
`else
    expBusy = 4;
`endif
    chk("t6 busy", 32'(firstBusy), 32'(expBusy));
    load("t6 fwd", 32'h30, 32'd6);
    waitEmpty("t6 empty");
    load("t6 array", 32'h30, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
